// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command sender with filtered line inputs, request-to-send, ACK check and timeouts.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES        = 12000,
  parameter int unsigned START_TIMEOUT_CYCLES  = 1500000,
  parameter int unsigned PACKET_TIMEOUT_CYCLES = 200000,
  parameter int unsigned FILTER_LEN            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, START, RTS, SEND, ACK, WAIT_IDLE} state_t;
  state_t state;
  logic [1:0] pad, filt;
  logic clk_q, fall, abort;
  logic [9:0] frame;
  logic [3:0] idx;
  logic [31:0] timer;
  assign pad = {ps2_data_in, ps2_clk_in};
  for (genvar i = 0; i < 2; i++) begin : g_filt
    logic [1:0] s;
    logic f;
    logic [FW-1:0] n;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        s <= 2'b11;
        f <= 1'b1;
        n <= '0;
      end else begin
        s <= {s[0], pad[i]};
        n <= (s[1] == f || n == FW'(FILTER_LEN - 1)) ? '0 : n + FW'(1);
        if (s[1] != f && n == FW'(FILTER_LEN - 1)) f <= s[1];
      end
    assign filt[i] = f;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) clk_q <= 1'b1;
    else clk_q <= filt[0];
  assign fall = clk_q & ~filt[0];
  // The packet timer runs from the first device edge through the final idle wait.
  always_comb
    abort = (state == RTS) ? (!fall && timer > START_TIMEOUT_CYCLES) :
            (state == SEND || state == ACK || state == WAIT_IDLE) ? (timer > PACKET_TIMEOUT_CYCLES) : 1'b0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      frame <= '0;
      idx <= '0;
      timer <= '0;
      tx_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      ack_ok <= 1'b0;
      err_timeout <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      err_timeout <= 1'b0;
      timer <= (&timer) ? timer : timer + 32'd1;
      if (abort) begin
        ps2_clk_oe <= 1'b0;
        ps2_data_oe <= 1'b0;
        err_timeout <= 1'b1;
        busy <= 1'b0;
        tx_ready <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE:
            if (tx_valid && tx_ready) begin
              frame <= {1'b1, ~^tx_data, tx_data};
              tx_ready <= 1'b0;
              busy <= 1'b1;
              ack_ok <= 1'b0;
              ps2_clk_oe <= 1'b1;
              timer <= '0;
              state <= INHIBIT;
            end
          INHIBIT:
            if (timer >= INHIBIT_CYCLES - 1) begin
              ps2_data_oe <= 1'b1;
              state <= START;
            end
          START: begin
            ps2_clk_oe <= 1'b0;
            timer <= '0;
            state <= RTS;
          end
          RTS:
            if (fall) begin
              ps2_data_oe <= ~frame[0];
              idx <= 4'd1;
              timer <= '0;
              state <= SEND;
            end
          SEND:
            if (fall) begin
              ps2_data_oe <= ~frame[idx];
              idx <= idx + 4'd1;
              if (idx == 4'd9) state <= ACK;
            end
          ACK:
            if (fall) begin
              ack_ok <= ~filt[1];
              state <= WAIT_IDLE;
            end
          WAIT_IDLE:
            if (&filt) begin
              done <= 1'b1;
              busy <= 1'b0;
              tx_ready <= 1'b1;
              state <= IDLE;
            end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 device model checking frames, ACK, timeout, glitch and reset behaviour.
module tb_ps2_host_tx;
  localparam int IC = 20, ST = 400, PT = 2500, FL = 4, H = 30;
  logic clk = 0, rst = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err_timeout;
  logic dev_clk = 1, dev_data = 1, glitch = 0;
  logic clk_pad, data_pad;
  int vectors = 0, errors = 0, cyc = 0;
  logic seen_done, seen_err, seen_ack, seen_both;
  assign clk_pad = ~ps2_clk_oe & dev_clk & ~glitch;
  assign data_pad = ~ps2_data_oe & dev_data;
  ps2_host_tx #(.INHIBIT_CYCLES(IC), .START_TIMEOUT_CYCLES(ST), .PACKET_TIMEOUT_CYCLES(PT), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ps2_clk_in(clk_pad), .ps2_data_in(data_pad), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .ack_ok(ack_ok), .err_timeout(err_timeout));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done) begin
      seen_done = 1;
      seen_ack = ack_ok;
    end
    if (err_timeout) seen_err = 1;
    if (done && err_timeout) seen_both = 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear_seen();
    seen_done = 0;
    seen_err = 0;
    seen_ack = 0;
    seen_both = 0;
  endtask
  task automatic wait_rts(output bit ok);
    int n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < IC + 200) begin
      @(negedge clk);
      n++;
    end
    ok = (n < IC + 200);
  endtask
  task automatic dev_frame(input bit ack, input bit glt, input int stop_at, output logic [9:0] rx, output bit ok);
    bit rts;
    rx = '0;
    ok = 0;
    wait_rts(rts);
    if (!rts) return;
    tick(50);
    chk("start_bit", 32'(data_pad), 0);
    for (int k = 1; k <= 11; k++) begin
      if (k == stop_at) begin
        ok = 1;
        return;
      end
      dev_clk = 0;
      tick(H);
      dev_clk = 1;
      if (k <= 10) rx[k-1] = data_pad;
      tick(8);
      if (glt && k == 4) glitch = 1;
      tick(3);
      glitch = 0;
      tick(4);
      if (k == 10 && ack) dev_data = 0;
      if (k == 11) dev_data = 1;
      tick(H - 15);
    end
    ok = 1;
  endtask
  task automatic accept(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1;
    tx_data = d;
    tick(1);
    tx_valid = 0;
    @(negedge clk);
    chk("busy_acc", 32'(busy), 1);
    chk("ready_acc", 32'(tx_ready), 0);
  endtask
  task automatic run_frame(input logic [7:0] d, input bit ack, input bit glt);
    logic [9:0] rx;
    bit ok;
    int n;
    bit par;
    clear_seen();
    accept(d);
    tick(3);
    tx_valid = 1;
    tx_data = ~d;
    tick(1);
    tx_valid = 0;
    dev_frame(ack, glt, 0, rx, ok);
    chk("dev_ok", 32'(ok), 1);
    par = ($countones(d) % 2 == 0);
    chk("bits", 32'(rx), 32'({1'b1, par, d}));
    n = 0;
    while (!seen_done && !seen_err && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("done", 32'(seen_done), 1);
    chk("ack_ok", 32'(seen_ack), 32'(ack));
    chk("no_err", 32'(seen_err), 0);
    chk("no_both", 32'(seen_both), 0);
    chk("ready_end", 32'(tx_ready), 1);
    chk("busy_end", 32'(busy), 0);
    chk("oe_end", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    tick(10);
    chk("ack_hold", 32'(ack_ok), 32'(ack));
  endtask
  initial begin
    bit ok;
    int n, t0;
    logic [9:0] rx;
    clear_seen();
    tick(3);
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_outs", 32'({busy, done, ack_ok, err_timeout, ps2_clk_oe, ps2_data_oe}), 0);
    rst = 1;
    tick(5);
    run_frame(8'hED, 1, 0);
    run_frame(8'h01, 1, 0);
    run_frame(8'hFF, 1, 0);
    run_frame(8'h00, 1, 0);
    run_frame(8'h3C, 0, 0);
    run_frame(8'hED, 1, 1);
    clear_seen();
    accept(8'h55);
    wait_rts(ok);
    chk("to_rts", 32'(ok), 1);
    t0 = cyc;
    n = 0;
    while (!seen_err && n < ST + 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_lat", 32'((cyc - t0) >= ST && (cyc - t0) <= ST + 4), 1);
    chk("to_err", 32'(seen_err), 1);
    chk("to_no_done", 32'(seen_done), 0);
    chk("to_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    chk("to_ready", 32'(tx_ready), 1);
    tick(5);
    clear_seen();
    accept(8'hA5);
    dev_frame(1, 0, 4, rx, ok);
    chk("rst_dev", 32'(ok), 1);
    #2;
    rst = 0;
    #1;
    chk("rst_mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    chk("rst_mid_rdy", 32'({tx_ready, busy}), 32'b10);
    tick(3);
    rst = 1;
    tick(5);
    chk("rst_after_rdy", 32'(tx_ready), 1);
    chk("rst_no_pulse", 32'({seen_done, seen_err}), 0);
    run_frame(8'hF4, 1, 0);
    for (int i = 0; i < 6; i++) run_frame(8'($urandom), 1'($urandom), 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
